ls_station: RTL

Four-entry in-order load/store issue station sitting directly upstream of `store_queue`. It accepts memory instructions from dispatch and tracks readiness of their source physical registers by snooping the CDB. It issues the oldest instruction, with its physical-register read addresses, to the register file and `store_queue` once both operands are ready. It also honours `sq_full`, `stall_hazard` and ROB recovery.

---
 rtl/ls_station_if.sv | 41 ++++
 rtl/ls_station.sv | 113 +++++++++++
 2 files changed

// File: rtl/ls_station_if.sv
// Dispatch, CDB snoop, downstream-control and issue signals of the load/store issue station.
// The slave modport is the station's view; master is the surrounding pipeline's view.
interface ls_station_if;
  logic        dispatch;
  logic        d_mem_ren;
  logic        d_mem_wen;
  logic [15:0] d_immed;
  logic [3:0]  d_rob;
  logic [5:0]  d_p_rs;
  logic [5:0]  d_p_rt;
  logic [5:0]  d_p_rd;
  logic        d_rs_rdy;
  logic        d_rt_rdy;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic        sq_full;
  logic        stall_hazard;
  logic        recover;
  logic [3:0]  rec_rob;
  logic        lss_full;
  logic        issue;
  logic        mem_ren;
  logic        mem_wen;
  logic [15:0] immed;
  logic [3:0]  rob_out;
  logic [5:0]  p_rs_out;
  logic [5:0]  p_rt_out;
  logic [5:0]  p_rd_out;

  modport master (
    output dispatch, d_mem_ren, d_mem_wen, d_immed, d_rob, d_p_rs, d_p_rt, d_p_rd,
           d_rs_rdy, d_rt_rdy, cdb_valid, cdb_tag, sq_full, stall_hazard, recover, rec_rob,
    input  lss_full, issue, mem_ren, mem_wen, immed, rob_out, p_rs_out, p_rt_out, p_rd_out
  );

  modport slave (
    input  dispatch, d_mem_ren, d_mem_wen, d_immed, d_rob, d_p_rs, d_p_rt, d_p_rd,
           d_rs_rdy, d_rt_rdy, cdb_valid, cdb_tag, sq_full, stall_hazard, recover, rec_rob,
    output lss_full, issue, mem_ren, mem_wen, immed, rob_out, p_rs_out, p_rt_out, p_rd_out
  );
endinterface

// File: rtl/ls_station.sv
// In-order load/store issue station: a circular buffer that snoops the CDB for operand
// readiness and issues only its oldest entry; recovery squashes from the young end.
module ls_station #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  ls_station_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic        valid  [DEPTH];
  logic        ren    [DEPTH];
  logic        wen    [DEPTH];
  logic [15:0] immed  [DEPTH];
  logic [3:0]  rob    [DEPTH];
  logic [5:0]  p_rs   [DEPTH];
  logic [5:0]  p_rt   [DEPTH];
  logic [5:0]  p_rd   [DEPTH];
  logic        rs_rdy [DEPTH];
  logic        rt_rdy [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  logic [PW:0]   count;
  logic          head_ready;
  logic          do_issue;
  logic          do_enq;
  logic          do_squash;
  logic          d_rs_wake;
  logic          d_rt_wake;

  assign last        = tail - PW'(1);
  assign bus.lss_full = (count == FULL_COUNT);

  // Only registered ready bits count, so a CDB wakeup becomes issuable the next cycle.
  assign head_ready = rs_rdy[head] && (!wen[head] || rt_rdy[head]);
  assign do_issue   = valid[head] && head_ready && !bus.sq_full && !bus.stall_hazard && !bus.recover;
  assign do_enq     = bus.dispatch && !bus.lss_full && !bus.recover && (bus.d_mem_ren || bus.d_mem_wen);
  assign do_squash  = bus.recover && valid[last] && (rob[last] == bus.rec_rob);
  assign d_rs_wake  = bus.cdb_valid && (bus.d_p_rs == bus.cdb_tag);
  assign d_rt_wake  = bus.cdb_valid && (bus.d_p_rt == bus.cdb_tag);
  assign bus.issue  = do_issue;

  always_comb begin
    bus.mem_ren  = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.immed    = '0;
    bus.rob_out  = '0;
    bus.p_rs_out = '0;
    bus.p_rt_out = '0;
    bus.p_rd_out = '0;
    if (valid[head]) begin
      bus.mem_ren  = ren[head];
      bus.mem_wen  = wen[head];
      bus.immed    = immed[head];
      bus.rob_out  = rob[head];
      bus.p_rs_out = p_rs[head];
      bus.p_rt_out = p_rt[head];
      bus.p_rd_out = p_rd[head];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid[i]  <= 1'b0;
        ren[i]    <= 1'b0;
        wen[i]    <= 1'b0;
        immed[i]  <= '0;
        rob[i]    <= '0;
        p_rs[i]   <= '0;
        p_rt[i]   <= '0;
        p_rd[i]   <= '0;
        rs_rdy[i] <= 1'b0;
        rt_rdy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_valid && (p_rs[i] == bus.cdb_tag)) rs_rdy[i] <= 1'b1;
        if (bus.cdb_valid && (p_rt[i] == bus.cdb_tag)) rt_rdy[i] <= 1'b1;
      end
      if (do_issue) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (do_squash) begin
        valid[last] <= 1'b0;
        tail        <= last;
      end
      // The enqueue slot is free, so these writes override any wakeup aimed at stale contents.
      if (do_enq) begin
        valid[tail]  <= 1'b1;
        ren[tail]    <= bus.d_mem_ren;
        wen[tail]    <= bus.d_mem_wen;
        immed[tail]  <= bus.d_immed;
        rob[tail]    <= bus.d_rob;
        p_rs[tail]   <= bus.d_p_rs;
        p_rt[tail]   <= bus.d_p_rt;
        p_rd[tail]   <= bus.d_p_rd;
        rs_rdy[tail] <= bus.d_rs_rdy || d_rs_wake;
        rt_rdy[tail] <= bus.d_rt_rdy || d_rt_wake;
        tail         <= tail + PW'(1);
      end
      count <= count + (PW+1)'(do_enq) - (PW+1)'(do_issue) - (PW+1)'(do_squash);
    end
  end
endmodule
